// File: rtl/ltc2308_ctrl_if.sv
// SPI pin bundle between the LTC2308 controller (master) and the ADC (slave).
interface ltc2308_ctrl_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sck, output cs, output mosi, input miso);
    modport slave  (input sck, input cs, input mosi, output miso);
endinterface

// File: rtl/ltc2308_ctrl.sv
// Free-running LTC2308 SPI master: converts, shifts 12 result bits per frame while sending the
// next slot's config word, and keeps the latest result for each of three round-robin slots.
module ltc2308_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int GAP_CYCLES  = 16
) (
    input  logic          clk_50,
    input  logic          reset,
    ltc2308_ctrl_if.master spi,
    input  logic          mode_in,
    output logic [11:0]   reading0,
    output logic [11:0]   reading1,
    output logic [11:0]   reading2
);
    localparam int PW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    typedef enum logic [1:0] {CONV, SHIFT, STORE, GAP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [3:0]    bit_idx, bit_nxt;

    logic          cs_d, sck_d, mosi_d, sample;
    logic [5:0]    cfg, cfg_sel;
    logic [11:0]   rx;
    logic [1:0]    slot, prev_slot;
    logic          prev_valid;
    logic          sck_q, cs_q, mosi_q;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state   <= CONV;
            cnt     <= '0;
            phase   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            phase   <= phase_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        bit_nxt   = bit_idx;
        case (state)
            CONV: begin
                if (cnt == 16'(CONV_CYCLES - 1)) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    phase_nxt = '0;
                    bit_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            SHIFT: begin
                if (phase == PW'(2 * CLK_DIV - 1)) begin
                    phase_nxt = '0;
                    if (bit_idx == 4'd11) state_nxt = STORE;
                    else                  bit_nxt   = bit_idx + 4'd1;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            STORE: begin
                state_nxt = GAP;
                cnt_nxt   = '0;
            end
            GAP: begin
                if (cnt == 16'(GAP_CYCLES - 1)) begin
                    state_nxt = CONV;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = CONV;
        endcase
    end

    // Pins are registered, so they trail the state by one cycle; miso is taken on the
    // edge that launches sck high, which is the same edge that registers the rise.
    always_comb begin
        cs_d   = (state == CONV);
        sck_d  = (state == SHIFT) && (phase >= PW'(CLK_DIV));
        mosi_d = 1'b0;
        if (state == SHIFT && bit_idx < 4'd6) mosi_d = cfg[3'd5 - bit_idx[2:0]];
        sample = (state == SHIFT) && (phase == PW'(CLK_DIV));
    end

    always_comb begin
        cfg_sel = {2'b00, slot, 2'b10};
        if (mode_in) begin
            case (slot)
                2'd0:    cfg_sel = 6'b100010;
                2'd1:    cfg_sel = 6'b110010;
                default: cfg_sel = 6'b100110;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sck_q      <= 1'b0;
            cs_q       <= 1'b0;
            mosi_q     <= 1'b0;
            cfg        <= '0;
            rx         <= '0;
            slot       <= '0;
            prev_slot  <= '0;
            prev_valid <= 1'b0;
            reading0   <= '0;
            reading1   <= '0;
            reading2   <= '0;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
            if (state == CONV && cnt == '0) cfg <= cfg_sel;
            if (sample) rx <= {rx[10:0], spi.miso};
            // The ADC answers one frame late, so rx belongs to the previous frame's slot.
            if (state == STORE) begin
                if (prev_valid) begin
                    case (prev_slot)
                        2'd0:    reading0 <= rx;
                        2'd1:    reading1 <= rx;
                        default: reading2 <= rx;
                    endcase
                end
                prev_slot  <= slot;
                prev_valid <= 1'b1;
                slot       <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            end
        end
    end

    assign spi.sck  = sck_q;
    assign spi.cs   = cs_q;
    assign spi.mosi = mosi_q;
endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Scoreboard bench for ltc2308_ctrl: a directed frame table feeds an ADC model and expected
// queues; a monitor decodes each SPI frame and checks config bits, timing and readings.
module tb_ltc2308_ctrl;
    logic        clk_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        mode_in = 1'b1;
    logic [11:0] reading0, reading1, reading2;
    logic        miso_m = 1'b0;

    ltc2308_ctrl_if spi();
    assign spi.miso = miso_m;

    ltc2308_ctrl dut (
        .clk_50  (clk_50),
        .reset   (reset),
        .spi     (spi),
        .mode_in (mode_in),
        .reading0(reading0),
        .reading1(reading1),
        .reading2(reading2)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        bit          abort;
        bit          mode;
        bit          tog;
        logic [11:0] word;
        logic [5:0]  cfg;
        logic [11:0] r0, r1, r2;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] adc_q[$];
    logic [11:0] exp_mosi[$];
    logic [35:0] exp_rd[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit abort, input bit mode, input bit tog, input logic [11:0] word,
                       input logic [5:0] cfg, input logic [11:0] r0, input logic [11:0] r1,
                       input logic [11:0] r2);
        vec_t v;
        v.abort = abort; v.mode = mode; v.tog = tog; v.word = word;
        v.cfg = cfg; v.r0 = r0; v.r1 = r1; v.r2 = r2;
        vecs.push_back(v);
    endtask

    // ADC model: MSB valid when cs falls, next bit launched on each sck falling edge.
    logic        last_cs = 1'b0, last_sck = 1'b0;
    logic [11:0] adc_w = '0;
    int          adc_i = 0;
    always @(spi.cs or spi.sck) begin
        if (last_cs === 1'b1 && spi.cs === 1'b0) begin
            if (adc_q.size() > 0) adc_w = adc_q.pop_front();
            else                  adc_w = 12'h000;
            adc_i  = 0;
            miso_m = adc_w[11];
        end else if (last_sck === 1'b1 && spi.sck === 1'b0 && spi.cs === 1'b0) begin
            adc_i++;
            if (adc_i < 12) miso_m = adc_w[11 - adc_i];
        end
        last_cs  = spi.cs;
        last_sck = spi.sck;
    end

    // Monitor: one iteration per frame; a cs rise during the shift marks an aborted frame.
    initial begin
        time         t_rise;
        logic [11:0] got;
        int          n, extra;
        bit          aborted;
        wait (mon_en);
        @(posedge spi.cs);
        t_rise = $time;
        forever begin
            @(negedge spi.cs);
            check("cs_high_ns", 36'($time - t_rise), 36'd1600);
            got = '0; n = 0; aborted = 1'b0;
            while (n < 12 && !aborted) begin
                @(posedge spi.sck or posedge spi.cs);
                if (spi.cs === 1'b1) aborted = 1'b1;
                else begin
                    got[11 - n] = spi.mosi;
                    n++;
                end
            end
            if (!aborted) begin
                if (exp_mosi.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mosi_word: got %h expected none queued", got);
                end else begin
                    check("mosi_word", 36'(got), 36'(exp_mosi.pop_front()));
                end
                extra = 0;
                do begin
                    @(posedge spi.sck or posedge spi.cs);
                    if (spi.cs !== 1'b1) extra++;
                end while (spi.cs !== 1'b1);
                check("sck_extra_pulses", 36'(extra), 36'd0);
                check("frame_ns", 36'($time - t_rise), 36'd2900);
            end
            t_rise = $time;
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL readings: got %h expected none queued", {reading0, reading1, reading2});
            end else begin
                check("readings", {reading0, reading1, reading2}, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   first;
        //  abort mode tog  adc word  cfg         reading0 reading1 reading2 after STORE
        add(0, 1, 0, 12'hA5C, 6'b100010, 12'h000, 12'h000, 12'h000);
        add(0, 1, 0, 12'hA5C, 6'b110010, 12'hA5C, 12'h000, 12'h000);
        add(0, 1, 0, 12'hA5C, 6'b100110, 12'hA5C, 12'hA5C, 12'h000);
        add(0, 1, 0, 12'hA5C, 6'b100010, 12'hA5C, 12'hA5C, 12'hA5C);
        add(0, 0, 1, 12'h123, 6'b000110, 12'h123, 12'hA5C, 12'hA5C);
        add(0, 1, 1, 12'hFFF, 6'b100110, 12'h123, 12'hFFF, 12'hA5C);
        add(0, 0, 0, 12'h000, 6'b000010, 12'h123, 12'hFFF, 12'h000);
        add(0, 0, 1, 12'h800, 6'b000110, 12'h800, 12'hFFF, 12'h000);
        add(1, 1, 0, 12'h3C3, 6'b100110, 12'h000, 12'h000, 12'h000);
        add(0, 1, 0, 12'h7E1, 6'b100010, 12'h000, 12'h000, 12'h000);
        add(0, 0, 1, 12'h5A5, 6'b000110, 12'h5A5, 12'h000, 12'h000);
        add(0, 0, 0, 12'h001, 6'b001010, 12'h5A5, 12'h001, 12'h000);

        repeat (5) @(posedge clk_50);
        #1;
        check("reset_pins", 36'({spi.sck, spi.cs, spi.mosi}), 36'd0);
        check("reset_readings", {reading0, reading1, reading2}, 36'd0);
        @(negedge clk_50);
        reset  = 1'b0;
        mon_en = 1'b1;
        first  = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            mode_in = v.mode;
            adc_q.push_back(v.word);
            if (!v.abort) exp_mosi.push_back({v.cfg, 6'b000000});
            exp_rd.push_back({v.r0, v.r1, v.r2});
            if (first) begin
                @(posedge clk_50);
                #1;
                check("cs_rise_after_release", 36'(spi.cs), 36'd1);
                first = 1'b0;
            end
            if (v.abort) begin
                repeat (100) @(negedge clk_50);
                reset = 1'b1;
                repeat (3) @(negedge clk_50);
                check("midreset_pins", 36'({spi.sck, spi.cs, spi.mosi}), 36'd0);
                check("midreset_readings", {reading0, reading1, reading2}, 36'd0);
                reset = 1'b0;
                first = 1'b1;
            end else begin
                repeat (60) @(negedge clk_50);
                if (v.tog) mode_in = ~v.mode;
                repeat (85) @(negedge clk_50);
            end
        end

        wait (exp_rd.size() == 0 && exp_mosi.size() == 0);
        repeat (2) @(negedge clk_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
